axis_oscilloscope_mc: RTL and testbench

//  Multi-channel capture controller for a circular sample buffer. Sits between the ADC AXIS stream and the buffer writer.

---
 rtl/axis_osc_pkg.sv | 19 +
 rtl/axis_osc_trig_detect.sv | 73 +++++++
 rtl/axis_oscilloscope_mc.sv | 185 ++++++++++++++++++
 tb/tb_axis_oscilloscope_mc.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_osc_pkg.sv
// axis_osc_pkg
//   Shared types and constants for the multi-channel oscilloscope capture
//   controller: capture state encoding and trigger source/edge selectors.
package axis_osc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } osc_state_t;

    localparam logic TRG_SRC_EXT   = 1'b0;
    localparam logic TRG_SRC_INT   = 1'b1;
    localparam logic TRG_EDGE_RISE = 1'b0;
    localparam logic TRG_EDGE_FALL = 1'b1;

endpackage

// File: rtl/axis_osc_trig_detect.sv
// axis_osc_trig_detect
//   Level-crossing detector for the internal trigger. Selects one channel from
//   the packed sample word, remembers the previous accepted sample while armed
//   and flags a signed threshold crossing in the same cycle as the sample.
// Ports
//   aclk, aresetn  clock, synchronous active-low reset
//   arm_i          controller is in ARMED; low clears the history
//   valid_i        a sample is accepted this cycle
//   tdata_i        packed channel samples
//   chan_i         channel index to watch
//   edge_i         0 = rising, 1 = falling
//   level_i        signed threshold
//   hit_o          crossing detected on the current accepted sample
module axis_osc_trig_detect
    import axis_osc_pkg::*;
#(
    parameter int CHAN_NUM     = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int CHAN_SEL_W   = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             arm_i,
    input  logic                             valid_i,
    input  logic [CHAN_NUM*SAMPLE_WIDTH-1:0] tdata_i,
    input  logic [CHAN_SEL_W-1:0]            chan_i,
    input  logic                             edge_i,
    input  logic [SAMPLE_WIDTH-1:0]          level_i,
    output logic                             hit_o
);

    logic signed [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic                           prev_valid_q, prev_valid_d;
    logic signed [SAMPLE_WIDTH-1:0] cur;
    logic signed [SAMPLE_WIDTH-1:0] level;
    logic                           rise, fall;

    always_comb begin
        cur = '0;
        for (int k = 0; k < CHAN_NUM; k++) begin
            if (chan_i == CHAN_SEL_W'(k)) begin
                cur = tdata_i[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        level = level_i;

        // History only lives inside ARMED, so the first armed sample never fires.
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (!arm_i) begin
            prev_valid_d = 1'b0;
        end else if (valid_i) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
        end

        rise  = (prev_q < level) && (cur >= level);
        fall  = (prev_q > level) && (cur <= level);
        hit_o = arm_i && valid_i && prev_valid_q &&
                ((edge_i == TRG_EDGE_FALL) ? fall : rise);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/axis_oscilloscope_mc.sv
// axis_oscilloscope_mc
//   Capture controller between the ADC AXIS stream and a circular buffer
//   writer. Records a pre-trigger window, arms, triggers on an external flag or
//   a level crossing, records a post-trigger window and reports the buffer
//   address of the trigger sample.
// Ports
//   aclk, aresetn               clock, synchronous active-low reset
//   run_flag                    capture enable (level)
//   trg_flag/src/edge/chan/level trigger configuration and external flag
//   pre_data, post_data         window lengths (post includes trigger sample)
//   auto_data                   auto-trigger timeout in ARMED cycles
//   sts_addr/busy/done/auto     status
//   s_axis_*, m_axis_*          sample pass-through, gated by busy
// Build option
//   AXIS_OSC_AUTO_TRIG_EN       enables the ARMED timeout trigger
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for run_flag
// ST_PRE   | filling the pre-trigger window
// ST_ARMED | waiting for a trigger event
// ST_POST  | filling the post-trigger window
// ST_DONE  | capture complete, waiting for run_flag to drop
module axis_oscilloscope_mc
    import axis_osc_pkg::*;
#(
    parameter int CHAN_NUM     = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int CNTR_WIDTH   = 12
) (
    input  logic                                          aclk,
    input  logic                                          aresetn,
    input  logic                                          run_flag,
    input  logic                                          trg_flag,
    input  logic                                          trg_src,
    input  logic                                          trg_edge,
    input  logic [((CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1)-1:0] trg_chan,
    input  logic [SAMPLE_WIDTH-1:0]                       trg_level,
    input  logic [CNTR_WIDTH-1:0]                         pre_data,
    input  logic [CNTR_WIDTH-1:0]                         post_data,
    input  logic [31:0]                                   auto_data,
    output logic [CNTR_WIDTH-1:0]                         sts_addr,
    output logic                                          sts_busy,
    output logic                                          sts_done,
    output logic                                          sts_auto,
    output logic                                          s_axis_tready,
    input  logic [CHAN_NUM*SAMPLE_WIDTH-1:0]              s_axis_tdata,
    input  logic                                          s_axis_tvalid,
    output logic [CHAN_NUM*SAMPLE_WIDTH-1:0]              m_axis_tdata,
    output logic                                          m_axis_tvalid
);

    localparam int CHAN_SEL_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;

    osc_state_t            state_q, state_d;
    logic [CNTR_WIDTH-1:0] addr_q, addr_d;
    logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
    logic [CNTR_WIDTH-1:0] sts_addr_q, sts_addr_d;
    logic                  sts_busy_q, sts_busy_d;
    logic                  sts_done_q, sts_done_d;
    logic                  sts_auto_q, sts_auto_d;
    logic [CNTR_WIDTH-1:0] cntr_inc, cntr_trig;
    logic                  accept, armed, ext_hit, lvl_hit, int_hit, auto_hit, trig;

    assign accept        = s_axis_tvalid & sts_busy_q;
    assign armed         = (state_q == ST_ARMED);
    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = accept;
    assign sts_addr      = sts_addr_q;
    assign sts_busy      = sts_busy_q;
    assign sts_done      = sts_done_q;
    assign sts_auto      = sts_auto_q;

    assign cntr_inc  = cntr_q + {{(CNTR_WIDTH-1){1'b0}}, accept};
    assign cntr_trig = {{(CNTR_WIDTH-1){1'b0}}, accept};
    assign ext_hit   = armed && (trg_src == TRG_SRC_EXT) && trg_flag;
    assign int_hit   = lvl_hit && (trg_src == TRG_SRC_INT);
    assign trig      = ext_hit || int_hit || auto_hit;

    axis_osc_trig_detect #(
        .CHAN_NUM     (CHAN_NUM),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .CHAN_SEL_W   (CHAN_SEL_W)
    ) u_trig_detect (
        .aclk    (aclk),
        .aresetn (aresetn),
        .arm_i   (armed),
        .valid_i (accept),
        .tdata_i (s_axis_tdata),
        .chan_i  (trg_chan),
        .edge_i  (trg_edge),
        .level_i (trg_level),
        .hit_o   (lvl_hit)
    );

`ifdef AXIS_OSC_AUTO_TRIG_EN
    // timer_d counts the current ARMED cycle (1-based), so the forced trigger
    // lands on the auto_data-th cycle spent in ARMED.
    logic [31:0] timer_q, timer_d;
    assign timer_d  = armed ? (timer_q + 32'd1) : 32'd0;
    assign auto_hit = armed && (auto_data != 32'd0) && (timer_d == auto_data);

    always_ff @(posedge aclk) begin
        if (!aresetn) timer_q <= 32'd0;
        else          timer_q <= timer_d;
    end
`else
    logic unused_auto;
    assign unused_auto = ^auto_data;
    assign auto_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = accept ? (addr_q + 1'b1) : addr_q;
        cntr_d     = cntr_q;
        sts_addr_d = sts_addr_q;
        sts_auto_d = sts_auto_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_flag) begin
                    addr_d     = '0;
                    cntr_d     = '0;
                    sts_auto_d = 1'b0;
                    state_d    = ST_PRE;
                end
            end
            ST_PRE: begin
                if (!run_flag) begin
                    state_d = ST_IDLE;
                end else begin
                    cntr_d = cntr_inc;
                    if (cntr_inc >= pre_data) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!run_flag) begin
                    state_d = ST_IDLE;
                end else if (trig) begin
                    sts_addr_d = addr_q;
                    cntr_d     = cntr_trig;
                    // A real trigger in the same cycle takes credit over the timeout.
                    sts_auto_d = auto_hit && !ext_hit && !int_hit;
                    state_d    = (post_data <= cntr_trig) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (!run_flag) begin
                    state_d = ST_IDLE;
                end else begin
                    cntr_d = cntr_inc;
                    if (accept && (cntr_inc == post_data)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!run_flag) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        sts_busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
        sts_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cntr_q     <= '0;
            sts_addr_q <= '0;
            sts_busy_q <= 1'b0;
            sts_done_q <= 1'b0;
            sts_auto_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cntr_q     <= cntr_d;
            sts_addr_q <= sts_addr_d;
            sts_busy_q <= sts_busy_d;
            sts_done_q <= sts_done_d;
            sts_auto_q <= sts_auto_d;
        end
    end

endmodule

// File: tb/tb_axis_oscilloscope_mc.sv
module tb_axis_oscilloscope_mc;

    localparam int DEPTH = 4096;
    localparam int MAXC  = 4300;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        run_flag = 1'b0;
    logic        trg_flag = 1'b0;
    logic        trg_src = 1'b0;
    logic        trg_edge = 1'b0;
    logic [0:0]  trg_chan = 1'b0;
    logic [15:0] trg_level = '0;
    logic [11:0] pre_data = '0;
    logic [11:0] post_data = '0;
    logic [31:0] auto_data = '0;
    logic [11:0] sts_addr;
    logic        sts_busy, sts_done, sts_auto, s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;

    always #5 aclk = ~aclk;

    axis_oscilloscope_mc #(.CHAN_NUM(2), .SAMPLE_WIDTH(16), .CNTR_WIDTH(12)) dut (
        .aclk(aclk), .aresetn(aresetn), .run_flag(run_flag), .trg_flag(trg_flag),
        .trg_src(trg_src), .trg_edge(trg_edge), .trg_chan(trg_chan), .trg_level(trg_level),
        .pre_data(pre_data), .post_data(post_data), .auto_data(auto_data),
        .sts_addr(sts_addr), .sts_busy(sts_busy), .sts_done(sts_done), .sts_auto(sts_auto),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid)
    );

    int total = 0;
    int bad   = 0;
    int exp_addr = 0;
    bit exp_auto = 1'b0;

    // per-cycle stimulus; cycle 0 is the cycle in which run_flag first rises
    bit          vld[MAXC];
    bit          trg[MAXC];
    bit          run_a[MAXC];
    logic [31:0] dat[MAXC];

    function automatic int chsamp(logic [31:0] d, int ch);
        shortint s;
        s = (ch != 0) ? d[31:16] : d[15:0];
        return int'(s);
    endfunction

    function automatic bit crossed(int edg, int lvl, int p, int c);
        if (edg == 0) return (p < lvl) && (c >= lvl);
        return (p > lvl) && (c <= lvl);
    endfunction

    function automatic logic [31:0] pack2(int s1, int s0);
        logic [31:0] r;
        r = {s1[15:0], s0[15:0]};
        return r;
    endfunction

    task automatic clear_stim(input int n, input int run_len);
        for (int i = 0; i < MAXC; i++) begin
            vld[i]   = (i < n);
            trg[i]   = 1'b0;
            run_a[i] = (i < run_len);
            dat[i]   = $urandom;
        end
    endtask

    // Scenario-level reference: derives window boundaries, trigger cycle and
    // completion cycle from the stimulus arrays, then checks every cycle.
    task automatic run_scenario(input string name, input int pre, input int post,
                                input int src, input int edg, input int chan,
                                input int lvl, input int autov, input int ncyc);
        int a, arm_c, t_c, d_c, cnt, c, prev, cur, auto_t;
        bit hp, ext, inh, au, be, de;

        a = ncyc;
        for (int i = 1; i < ncyc; i++) if (!run_a[i]) begin a = i; break; end

        arm_c = -1;
        if (pre == 0) begin
            if (a > 1) arm_c = 2;
        end else begin
            cnt = 0;
            for (int i = 1; i < a; i++) begin
                cnt += int'(vld[i]);
                if (cnt == pre) begin arm_c = i + 1; break; end
            end
        end

        exp_auto = 1'b0;
        auto_t   = -1;
`ifdef AXIS_OSC_AUTO_TRIG_EN
        if (arm_c >= 0 && autov != 0) auto_t = arm_c + autov - 1;
`endif
        t_c = -1;
        if (arm_c >= 0) begin
            hp = 1'b0;
            prev = 0;
            for (int i = arm_c; i < a; i++) begin
                cur = chsamp(dat[i], chan);
                ext = (src == 0) && trg[i];
                inh = (src == 1) && vld[i] && hp && crossed(edg, lvl, prev, cur);
                au  = (i == auto_t);
                if (ext || inh || au) begin
                    t_c = i;
                    exp_auto = au && !ext && !inh;
                    break;
                end
                if (vld[i]) begin prev = cur; hp = 1'b1; end
            end
        end

        d_c = -1;
        if (t_c >= 0) begin
            cnt = 0;
            for (int i = 1; i < t_c; i++) cnt += int'(vld[i]);
            exp_addr = cnt % DEPTH;
            c = int'(vld[t_c]);
            if (post <= c) d_c = t_c + 1;
            else begin
                for (int i = t_c + 1; i < a; i++) begin
                    c += int'(vld[i]);
                    if (c == post) begin d_c = i + 1; break; end
                end
            end
        end

        pre_data  = pre[11:0];
        post_data = post[11:0];
        trg_src   = src[0];
        trg_edge  = edg[0];
        trg_chan  = chan[0];
        trg_level = lvl[15:0];
        auto_data = autov;

        for (int i = 0; i < ncyc; i++) begin
            @(negedge aclk);
            run_flag      = run_a[i];
            s_axis_tvalid = vld[i];
            s_axis_tdata  = dat[i];
            trg_flag      = trg[i];
            #1;
            be = (i >= 1) && (i <= a) && (d_c < 0 || i < d_c);
            de = (d_c >= 0) && (i >= d_c) && (i <= a);
            total++;
            if (sts_busy !== be) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b want=%b", name, i, sts_busy, be);
            end
            total++;
            if (sts_done !== de) begin
                bad++;
                $display("FAIL %s done cyc=%0d got=%b want=%b", name, i, sts_done, de);
            end
            total++;
            if (m_axis_tvalid !== (vld[i] & be)) begin
                bad++;
                $display("FAIL %s m_tvalid cyc=%0d got=%b want=%b", name, i, m_axis_tvalid, vld[i] & be);
            end
            total++;
            if (m_axis_tdata !== dat[i] || s_axis_tready !== 1'b1) begin
                bad++;
                $display("FAIL %s passthru cyc=%0d tdata=%h want=%h tready=%b", name, i, m_axis_tdata, dat[i], s_axis_tready);
            end
        end
        total++;
        if (sts_addr !== exp_addr[11:0]) begin
            bad++;
            $display("FAIL %s sts_addr got=%0d want=%0d", name, sts_addr, exp_addr);
        end
        total++;
        if (sts_auto !== exp_auto) begin
            bad++;
            $display("FAIL %s sts_auto got=%b want=%b", name, sts_auto, exp_auto);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        run_flag = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (3) @(negedge aclk);
        total++;
        if (sts_busy !== 1'b0 || sts_done !== 1'b0 || sts_auto !== 1'b0 || sts_addr !== 12'd0) begin
            bad++;
            $display("FAIL reset status busy=%b done=%b auto=%b addr=%0d want 0", sts_busy, sts_done, sts_auto, sts_addr);
        end
        total++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset axis m_tvalid=%b want 0 tready=%b want 1", m_axis_tvalid, s_axis_tready);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        total++;
        if (sts_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset idle busy=%b want 0", sts_busy);
        end
        s_axis_tvalid = 1'b0;
        exp_addr = 0;
    endtask

    task automatic test_ext_basic();
        clear_stim(60, 50);
        trg[15] = 1'b1;
        run_scenario("ext_basic", 4, 8, 0, 0, 0, 0, 0, 60);
        clear_stim(0, 90);
        for (int i = 0; i < 100; i++) vld[i] = ($urandom_range(0, 2) != 0);
        trg[20] = 1'b1;
        trg[21] = 1'b1;
        run_scenario("ext_gappy", 5, 6, 0, 0, 0, 0, 0, 100);
    endtask

    task automatic test_int_ramp();
        clear_stim(30, 25);
        dat[1] = pack2(-5, 7);
        dat[2] = pack2(-5, 7);
        dat[3] = pack2(5, 7);
        for (int k = 0; k < 7; k++) dat[4 + k] = pack2(k - 3, 100);
        for (int k = 11; k < 30; k++) dat[k] = pack2(3, 100);
        run_scenario("int_rise", 2, 3, 1, 0, 1, 0, 0, 30);
        clear_stim(30, 25);
        dat[1] = pack2(0, 9);
        dat[2] = pack2(0, 9);
        dat[3] = pack2(0, -9);
        for (int k = 0; k < 7; k++) dat[4 + k] = pack2(0, 3 - k);
        for (int k = 11; k < 30; k++) dat[k] = pack2(0, -3);
        run_scenario("int_fall", 2, 4, 1, 1, 0, 0, 0, 30);
    endtask

    task automatic test_pre0_post1();
        clear_stim(20, 15);
        trg[4] = 1'b1;
        run_scenario("pre0_post1", 0, 1, 0, 0, 0, 0, 0, 20);
        clear_stim(20, 15);
        vld[4] = 1'b0;
        vld[5] = 1'b0;
        trg[4] = 1'b1;
        run_scenario("pre0_post1_novld", 0, 1, 0, 0, 0, 0, 0, 20);
    endtask

    task automatic test_wrap();
        clear_stim(4110, 4107);
        trg[4101] = 1'b1;
        run_scenario("wrap", 4090, 3, 0, 0, 0, 0, 0, 4110);
    endtask

    task automatic test_abort_restart();
        clear_stim(20, 15);
        trg[8] = 1'b1;
        run_scenario("abort_post", 4, 20, 0, 0, 0, 0, 0, 20);
        clear_stim(20, 15);
        trg[5] = 1'b1;
        run_scenario("restart", 1, 2, 0, 0, 0, 0, 0, 20);
    endtask

    task automatic test_auto();
        clear_stim(80, 75);
        run_scenario("auto", 3, 4, 0, 0, 0, 0, 50, 80);
    endtask

    task automatic test_reset_mid();
        pre_data  = 12'd3;
        post_data = 12'd20;
        trg_src   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            run_flag      = 1'b1;
            s_axis_tvalid = 1'b1;
            trg_flag      = (i == 8);
        end
        @(negedge aclk);
        total++;
        if (sts_addr !== 12'd7 || sts_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid pre addr=%0d want 7 busy=%b want 1", sts_addr, sts_busy);
        end
        aresetn = 1'b0;
        @(negedge aclk);
        total++;
        if (sts_addr !== 12'd0 || sts_busy !== 1'b0 || sts_done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid post addr=%0d busy=%b done=%b m_tvalid=%b want all 0", sts_addr, sts_busy, sts_done, m_axis_tvalid);
        end
        run_flag      = 1'b0;
        s_axis_tvalid = 1'b0;
        trg_flag      = 1'b0;
        aresetn       = 1'b1;
        exp_addr      = 0;
        @(negedge aclk);
    endtask

    task automatic test_random();
        int pre, post, src, edg, chan, lvl, autov, a, s0, s1;
        for (int n = 0; n < 10; n++) begin
            pre   = int'($urandom_range(0, 12));
            post  = int'($urandom_range(0, 12));
            src   = int'($urandom_range(0, 1));
            edg   = int'($urandom_range(0, 1));
            chan  = int'($urandom_range(0, 1));
            lvl   = int'($urandom_range(0, 200)) - 100;
            autov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            a     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 117)) : 117;
            clear_stim(0, a);
            for (int i = 0; i < 120; i++) begin
                s0 = int'($urandom_range(0, 300)) - 150;
                s1 = int'($urandom_range(0, 300)) - 150;
                dat[i] = pack2(s1, s0);
                vld[i] = ($urandom_range(0, 9) < 7);
                trg[i] = ($urandom_range(0, 19) == 0);
            end
            run_scenario("random", pre, post, src, edg, chan, lvl, autov, 120);
        end
    endtask

    initial begin
        test_reset();
        test_ext_basic();
        test_int_ramp();
        test_pre0_post1();
        test_wrap();
        test_abort_restart();
        test_auto();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
